// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - read-side burst controller turning sync_fifo reads into a framed valid/ready stream
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int OBUF_DEPTH = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic                  fifo_aempty,
    output logic                  read_req,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int IW = $clog2(BURST_LEN + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW:0]   DEPTH_C    = (CW + 1)'(OBUF_DEPTH);
    localparam logic [IW-1:0] BLEN_FULL  = IW'(BURST_LEN);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0]         blen;
    logic [IW-1:0]         issued;
    logic                  inflight;
    logic                  pend_last;
    logic                  flush_d;
    logic [TW-1:0]         timer;

    logic [DATA_WIDTH-1:0] mem_data [OBUF_DEPTH];
    logic                  mem_last [OBUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         occ;

    logic                  abort;
    logic                  push;
    logic                  pop;
    logic                  last_read;
    logic [CW:0]           fill;

    // Reset behaves as a flush for all control state.
    assign abort = reset || flush;

    // Buffer space already promised: stored words plus the one read in flight.
    assign fill = {1'b0, occ} + {{CW{1'b0}}, inflight};

    // The read that completes the burst carries the last marker.
    assign last_read = read_req && (issued == blen - IW'(1));

    // Only solicited data is stored, and nothing that lands around a flush.
    assign push = rdata_valid && inflight && !flush && !flush_d;

    assign pop = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: full bursts win over the idle timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!fifo_aempty) begin
                    state_next = S_BURST;
                end else if ((timer == TIMER_LAST) && !fifo_empty) begin
                    state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (last_read) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight && (occ == '0)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    // Outputs: reads only when the buffer can take the returning word.
    always_comb begin
        read_req  = 1'b0;
        busy      = (state != S_IDLE);
        out_valid = (occ != '0);
        if ((state == S_BURST) && !abort && !fifo_empty &&
            (fill < DEPTH_C) && (issued < blen)) begin
            read_req = 1'b1;
        end
    end

    assign out_data = mem_data[rd_ptr];
    assign out_last = out_valid && mem_last[rd_ptr];

    // Idle timer: runs while a partial burst waits in the FIFO.
    always_ff @(posedge clk) begin
        if (abort) begin
            timer <= '0;
        end else if ((state == S_IDLE) && (state_next == S_IDLE) &&
                     fifo_aempty && !fifo_empty) begin
            timer <= timer + TW'(1);
        end else begin
            timer <= '0;
        end
    end

    // Burst bookkeeping: length, issue count, in-flight read and its last flag.
    always_ff @(posedge clk) begin
        if (abort) begin
            issued    <= '0;
            inflight  <= 1'b0;
            pend_last <= 1'b0;
            if (reset) begin
                blen <= '0;
            end
        end else begin
            if ((state == S_IDLE) && (state_next == S_BURST)) begin
                blen   <= !fifo_aempty ? BLEN_FULL : IW'(1);
                issued <= '0;
            end else if (read_req) begin
                issued <= issued + IW'(1);
            end
            if (read_req) begin
                inflight  <= 1'b1;
                pend_last <= last_read;
            end else if (rdata_valid) begin
                inflight <= 1'b0;
            end
        end
    end

    // Remember an abort so the FIFO's late response is dropped one more cycle.
    always_ff @(posedge clk) begin
        flush_d <= abort;
    end

    // Output buffer: in-order storage of data plus last marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= read_data;
                mem_last[wr_ptr] <= pend_last;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader with a behavioural FIFO
module tb_fifo_burst_reader;

    localparam int DW     = 16;
    localparam int OD     = 4;
    localparam int AEMPTY = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          fifo_empty;
    logic          fifo_aempty;
    logic          read_req;
    logic [DW-1:0] read_data = '0;
    logic          rdata_valid = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;

    logic          wr_en;
    logic [DW-1:0] wr_data;

    int n_cmp = 0;
    int n_err = 0;

    fifo_burst_reader #(
        .DATA_WIDTH(16),
        .BURST_LEN (4),
        .OBUF_DEPTH(4),
        .TIMEOUT   (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_aempty(fifo_aempty),
        .read_req   (read_req),
        .read_data  (read_data),
        .rdata_valid(rdata_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural sync_fifo: one-cycle read latency, almost-empty at <= AEMPTY words.
    logic [DW-1:0] fmem [16];
    logic [3:0]    fwp  = '0;
    logic [3:0]    frp  = '0;
    logic [4:0]    fcnt = '0;
    logic          rd_go;

    assign fifo_empty  = (fcnt == 5'd0);
    assign fifo_aempty = (fcnt <= 5'(AEMPTY));
    assign rd_go       = read_req && (fcnt != 5'd0);

    always @(posedge clk) begin
        if (flush) begin
            fwp         <= '0;
            frp         <= '0;
            fcnt        <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= rd_go;
            if (rd_go) begin
                read_data <= fmem[frp];
                frp       <= frp + 4'd1;
            end
            if (wr_en) begin
                fmem[fwp] <= wr_data;
                fwp       <= fwp + 4'd1;
            end
            fcnt <= fcnt + 5'(wr_en) - 5'(rd_go);
        end
    end

    // Stream monitor, sampled mid-cycle.
    int            cyc = 0;
    logic [DW:0]   got [$];
    int            reads, acc, bp_viol, max_out, first_req, first_val, first_ne, reads_in_reset;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (read_req) begin
            if (reads - acc >= OD) bp_viol++;
            if (reset) reads_in_reset++;
            if (first_req < 0) first_req = cyc;
            reads++;
        end
        if (out_valid && first_val < 0) first_val = cyc;
        if (!fifo_empty && first_ne < 0) first_ne = cyc;
        if (out_valid && out_ready) begin
            got.push_back({out_last, out_data});
            acc++;
        end
        if (reads - acc > max_out) max_out = reads - acc;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        reads = 0; acc = 0; bp_viol = 0; max_out = 0;
        first_req = -1; first_val = -1; first_ne = -1; reads_in_reset = 0;
        got.delete();
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_got(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && got.size() < n; i++) step();
        check_eq(tag, got.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && busy; i++) step();
        check_eq(tag, busy, 1'b0);
    endtask

    task automatic check_word(input string tag, input int idx, input logic [DW-1:0] d, input logic l);
        logic [DW:0] w;
        w = (idx < got.size()) ? got[idx] : '1;
        check_eq({tag, "_data"}, w[DW-1:0], d);
        check_eq({tag, "_last"}, w[DW], l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
        clear_mon();
        step(); step(); step();
        check_eq("rst_read_req",  read_req,  1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_last",  out_last,  1'b0);
        check_eq("rst_out_data",  out_data,  16'h0000);
        check_eq("rst_busy",      busy,      1'b0);
        reset = 1'b0;
        step();

        // Two back-to-back full bursts with the sink always ready.
        clear_mon();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) write_word(DW'(i));
        wait_got("full_count", 8, 200);
        for (int i = 0; i < 8; i++) check_word("full", i, DW'(i + 1), (i == 3) || (i == 7));
        check_eq("full_reads",   reads, 8);
        check_eq("full_latency", first_val - first_req, 2);
        wait_idle("full_idle", 50);

        // Backpressure: buffer fills first, then sink toggles 1,0,0,1.
        clear_mon();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) write_word(DW'(i));
        for (int i = 0; i < 10; i++) step();
        for (int c = 0; c < 400 && got.size() < 8; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            step();
        end
        check_eq("bp_count", got.size(), 8);
        for (int i = 0; i < 8; i++) check_word("bp", i, DW'(i + 1), (i == 3) || (i == 7));
        check_eq("bp_max_outstanding", max_out, OD);
        check_eq("bp_read_over_space", bp_viol, 0);
        out_ready = 1'b1;
        wait_idle("bp_idle", 50);

        // Timeout: a lone word goes out as a single-word burst after 32 cycles.
        clear_mon();
        write_word(16'h00AA);
        wait_got("to_count", 1, 100);
        check_word("to", 0, 16'h00AA, 1'b1);
        check_eq("to_reads", reads, 1);
        check_eq("to_delay", first_req - first_ne, 32);
        wait_idle("to_idle", 50);

        // Flush after two words delivered with one read in flight.
        clear_mon();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) write_word(16'h0100 + DW'(i));
        for (int i = 0; i < 100 && acc < 2; i++) step();
        check_eq("fl_pre_acc", acc, 2);
        flush = 1'b1; out_ready = 1'b0;
        step();
        flush = 1'b0;
        check_eq("fl_out_valid", out_valid, 1'b0);
        check_eq("fl_busy",      busy,      1'b0);
        check_eq("fl_read_req",  read_req,  1'b0);
        out_ready = 1'b1;
        step(); step(); step();
        check_eq("fl_no_more_words", got.size(), 2);
        for (int i = 1; i <= 4; i++) write_word(16'h0200 + DW'(i));
        wait_got("fl_count", 6, 200);
        check_word("fl_w0", 0, 16'h0101, 1'b0);
        check_word("fl_w1", 1, 16'h0102, 1'b0);
        for (int i = 0; i < 4; i++) check_word("fl_new", i + 2, 16'h0201 + DW'(i), i == 3);
        wait_idle("fl_idle", 50);

        // Reset during DRAIN with three words buffered.
        clear_mon();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) write_word(16'h0300 + DW'(i));
        for (int i = 0; i < 100 && reads < 4; i++) step();
        step(); step(); step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("rd_pre_count", got.size(), 1);
        check_eq("rd_pre_busy",  busy, 1'b1);
        reset = 1'b1;
        step();
        check_eq("rd_read_req",  read_req,  1'b0);
        check_eq("rd_out_valid", out_valid, 1'b0);
        check_eq("rd_out_last",  out_last,  1'b0);
        check_eq("rd_out_data",  out_data,  16'h0000);
        check_eq("rd_busy",      busy,      1'b0);
        step(); step();
        reset = 1'b0;
        check_eq("rd_reads_in_reset", reads_in_reset, 0);
        got.delete();
        out_ready = 1'b1;
        wait_got("rd_count", 4, 100);
        for (int i = 0; i < 4; i++) check_word("rd_new", i, 16'h0305 + DW'(i), i == 3);
        wait_idle("rd_idle", 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller that sits on the read port of `sync_fifo` and turns its `read_req`/`rdata_valid` interface into a valid/ready stream with burst framing. The block issues FIFO reads only when it can guarantee space downstream and absorbs the one-cycle FIFO read latency in a small output buffer. It emits fixed-length bursts when enough data is queued, and emits single-word bursts when data has sat below the burst threshold for too long. It is the consumer counterpart of the FIFO write path and is instantiated next to `sync_fifo` in the same clock domain.

## Interface
- `DATA_WIDTH`, 16, word width; must match the FIFO.
- `BURST_LEN`, 4, words per full burst; must be ≤ FIFO `AEMPTY`+1.
- `OBUF_DEPTH`, 4, output buffer entries; power of two, ≥2.
- `TIMEOUT`, 32, idle cycles before a partial-data single-word burst; ≥1.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `flush`  in  1  synchronous abort; the parent drives the same signal to the FIFO `flush`.
- `fifo_empty`  in  1  from FIFO.
- `fifo_aempty`  in  1  from FIFO.
- `read_req`  out  1  to FIFO; combinational.
- `read_data`  in  DATA_WIDTH  from FIFO.
- `rdata_valid`  in  1  from FIFO; `read_data` is valid in the cycle after `read_req`.
- `out_data`  out  DATA_WIDTH  stream data.
- `out_valid`  out  1  stream valid.
- `out_last`  out  1  final word of the current burst; qualified by `out_valid`.
- `out_ready`  in  1  downstream accept.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **State machine.** States are IDLE, BURST and DRAIN.
- **IDLE to BURST (full burst).** Taken when `!fifo_aempty`. Latch `blen`=BURST_LEN and clear `issued`=0.
- **IDLE to BURST (timeout).** Taken when `timer`==TIMEOUT-1 and `!fifo_empty`. Latch `blen`=1.
- **Timer.** `timer` counts in IDLE while `fifo_aempty && !fifo_empty`. It clears in any other condition and on leaving IDLE.
- **Read issue.** In BURST, `read_req` = `!fifo_empty && (occ+inflight < OBUF_DEPTH) && issued < blen`. Each `read_req` increments `issued`.
- **In-flight tracking.** `inflight` is a 1-bit register set by `read_req` and cleared by `rdata_valid`.
- **BURST to DRAIN.** Taken on the cycle `issued` reaches `blen`.
- **DRAIN to IDLE.** Taken when `inflight`==0, the buffer is empty, and the last word has been accepted.
- **Output buffer.** FIFO-ordered with OBUF_DEPTH entries; `occ` is the registered occupancy.
  - Push on `rdata_valid`.
  - Pop on `out_valid && out_ready`.
  - A simultaneous push and pop leaves `occ` unchanged.
  - Each entry stores data plus a last bit.
- **Last-word marking.** The last bit is set on the word whose read was issued with `issued`==`blen`-1.
- **Head outputs.** `out_valid` = `occ`!=0. `out_data` and `out_last` come from the head entry.
- **Unsolicited data.** `rdata_valid` with `inflight`==0 is ignored and not pushed.
- **Burst integrity.** Full bursts never stall for data, because the `!fifo_aempty` entry condition guarantees `blen` words and this block is the FIFO's sole reader. Even so, `read_req` must stay gated by `!fifo_empty`.
- **Flush.** Takes priority over every other event.
  - Next state is IDLE; `occ`, `inflight`, `issued` and `timer` clear to 0.
  - `read_req` is forced to 0 in the flush cycle.
  - `rdata_valid` arriving in the flush cycle or the cycle after is dropped.
- **Reset.** Identical to flush, and additionally clears buffer contents.
  - Reset values: `read_req`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0.

## Timing
- **FIFO read latency.** A `read_req` in cycle N pushes into the buffer at the end of N+1. `out_valid` rises at N+2 at the earliest.
- **IDLE to first read.** The `!fifo_aempty` condition is sampled in cycle N. The state is BURST in N+1, and the first `read_req` can occur in N+1.
- **Throughput.** With `out_ready` held high and OBUF_DEPTH ≥ 4, the block sustains one word per cycle within a burst.
- **Between bursts.** There is at least one IDLE cycle between bursts (DRAIN to IDLE to BURST).
- **Stream rules.**
  - `out_data` and `out_last` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer, except on flush or reset.
- **Timeout.** The single-word burst enters BURST exactly TIMEOUT cycles after the FIFO first becomes non-empty-but-aempty in IDLE.

## Test plan
- **Full burst.** Preload the FIFO with 8 words 0x0001..0x0008, hold `out_ready`=1 → outputs 0x0001..0x0004 with `out_last` on 0x0004, then 0x0005..0x0008 with `out_last` on 0x0008. There are 4 `read_req` per burst, and the first `out_valid` comes 2 cycles after the first `read_req`.
- **Backpressure.** Same preload with `out_ready` toggling 1,0,0,1,… → no data lost or duplicated, `occ` never exceeds 4, and `read_req` deasserts while `occ`+`inflight`=4.
- **Timeout.** Write 1 word 0x00AA into an empty FIFO → after 32 IDLE cycles, one `read_req`, then output 0x00AA with `out_last`=1, then `busy` returns to 0.
- **Flush mid-burst.** Assert `flush` for one cycle after 2 words are output and 1 word is in flight → `out_valid`=0 the next cycle, the in-flight word is discarded, and state is IDLE. New data written afterwards starts a fresh burst with correct `out_last`.
- **Reset mid-burst.** Assert `reset` during DRAIN with `occ`=3 → all outputs take their reset values the next cycle. No `read_req` is issued until `reset` deasserts and the FIFO is non-aempty.
